// File: rtl/debug_dump_if.sv
// debug_dump_if: control, UART byte and debug read-port signals between the dump sequencer and its environment
interface debug_dump_if #(
    parameter int NB_DATA = 32,
    parameter int N_BITS  = 8,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 7,
    parameter int NB_PC   = 7
);
    logic               start_i;
    logic               abort_i;
    logic               tx_idle_i;
    logic               tx_start_o;
    logic [N_BITS-1:0]  tx_data_o;
    logic               sel_reg_debug_o;
    logic [NB_REG-1:0]  addr_reg_o;
    logic [NB_DATA-1:0] data_reg_i;
    logic               sel_mem_debug_o;
    logic [NB_ADDR-1:0] addr_mem_o;
    logic [NB_DATA-1:0] data_mem_i;
    logic [NB_PC-1:0]   pc_i;
    logic               busy_o;
    logic               done_o;

    modport master (
        input  start_i, abort_i, tx_idle_i, data_reg_i, data_mem_i, pc_i,
        output tx_start_o, tx_data_o, sel_reg_debug_o, addr_reg_o,
               sel_mem_debug_o, addr_mem_o, busy_o, done_o
    );

    modport slave (
        output start_i, abort_i, tx_idle_i, data_reg_i, data_mem_i, pc_i,
        input  tx_start_o, tx_data_o, sel_reg_debug_o, addr_reg_o,
               sel_mem_debug_o, addr_mem_o, busy_o, done_o
    );
endinterface

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: dumps register file, data memory and PC over the tx_uart byte interface, LSB byte first
module debug_dump_sequencer #(
    parameter int NB_DATA       = 32,
    parameter int N_BITS        = 8,
    parameter int N_BYTES       = 4,
    parameter int NB_REG        = 5,
    parameter int N_REGISTER    = 32,
    parameter int NB_ADDR       = 7,
    parameter int N_MEMORY_DATA = 128,
    parameter int NB_PC         = 7
) (
    input logic         clock_i,
    input logic         reset_i,
    debug_dump_if.master bus
);
    localparam int NB_IDX = N_BYTES > 1 ? $clog2(N_BYTES) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, CAPTURE, SEND, WAIT_BUSY, WAIT_IDLE, NEXT, FINISH} state_t;
    typedef enum logic [1:0] {SEC_REG, SEC_MEM, SEC_PC} section_t;

    state_t             state;
    section_t           section;
    logic [NB_DATA-1:0] word;
    logic [NB_IDX-1:0]  byte_idx;
    logic [NB_REG-1:0]  addr_reg;
    logic [NB_ADDR-1:0] addr_mem;
    logic [N_BITS-1:0]  tx_data;
    logic               tx_start, sel_reg, sel_mem, busy, done;
    logic               last_byte;

    // the PC section is a single zero-extended byte
    assign last_byte = section == SEC_PC || byte_idx == NB_IDX'(N_BYTES - 1);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state    <= IDLE;
            section  <= SEC_REG;
            word     <= '0;
            byte_idx <= '0;
            addr_reg <= '0;
            addr_mem <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            sel_reg  <= 1'b0;
            sel_mem  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (bus.abort_i) begin
            state    <= IDLE;
            section  <= SEC_REG;
            byte_idx <= '0;
            addr_reg <= '0;
            addr_mem <= '0;
            tx_start <= 1'b0;
            sel_reg  <= 1'b0;
            sel_mem  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: if (bus.start_i) begin
                    state    <= ADDR;
                    section  <= SEC_REG;
                    addr_reg <= '0;
                    addr_mem <= '0;
                    busy     <= 1'b1;
                    sel_reg  <= 1'b1;
                    sel_mem  <= 1'b0;
                end
                ADDR: state <= CAPTURE;
                CAPTURE: begin
                    word     <= section == SEC_REG ? bus.data_reg_i :
                                section == SEC_MEM ? bus.data_mem_i :
                                {{(NB_DATA - NB_PC){1'b0}}, bus.pc_i};
                    byte_idx <= '0;
                    state    <= SEND;
                end
                SEND: if (bus.tx_idle_i) begin
                    tx_start <= 1'b1;
                    tx_data  <= word[N_BITS*byte_idx +: N_BITS];
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: if (!bus.tx_idle_i) state <= WAIT_IDLE;
                WAIT_IDLE: if (bus.tx_idle_i) begin
                    state    <= last_byte ? NEXT : SEND;
                    byte_idx <= last_byte ? byte_idx : byte_idx + NB_IDX'(1);
                end
                NEXT: begin
                    state <= section == SEC_PC ? FINISH : ADDR;
                    if (section == SEC_REG && addr_reg != NB_REG'(N_REGISTER - 1)) begin
                        addr_reg <= addr_reg + NB_REG'(1);
                    end else if (section == SEC_REG) begin
                        section  <= SEC_MEM;
                        addr_reg <= '0;
                        sel_reg  <= 1'b0;
                        sel_mem  <= 1'b1;
                    end else if (section == SEC_MEM && addr_mem != NB_ADDR'(N_MEMORY_DATA - 1)) begin
                        addr_mem <= addr_mem + NB_ADDR'(1);
                    end else if (section == SEC_MEM) begin
                        section  <= SEC_PC;
                        addr_mem <= '0;
                        sel_mem  <= 1'b0;
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    section  <= SEC_REG;
                    addr_reg <= '0;
                    addr_mem <= '0;
                    sel_reg  <= 1'b0;
                    sel_mem  <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_start_o      = tx_start;
    assign bus.tx_data_o       = tx_data;
    assign bus.sel_reg_debug_o = sel_reg;
    assign bus.addr_reg_o      = addr_reg;
    assign bus.sel_mem_debug_o = sel_mem;
    assign bus.addr_mem_o      = addr_mem;
    assign bus.busy_o          = busy;
    assign bus.done_o          = done;
endmodule
